channel_selector: RTL and testbench
===================================

// Module: channel_selector
// PURPOSE
//  Converts debounced UP/DOWN button levels into a wrapping channel index 0..N_CH-1 for the display path.
//  Each press steps the index once. Holding a button auto-repeats after HOLD_CYCLES, then every REPEAT_CYCLES.
//  Sits directly downstream of the per-button debouncers (consumes their db_level outputs).
//  Feeds the channel mux and display formatter.
// PARAMETERS
//  N_CH          13          number of channels; index range 0..N_CH-1 (N_CH >= 2)
//  CH_W          4           width of ch_idx; N_CH <= 2**CH_W
//  HOLD_CYCLES   50_000_000  cycles from first step to first auto-repeat step (0.5 s @ 100 MHz); >= 2
//  REPEAT_CYCLES 10_000_000  cycles between auto-repeat steps (0.1 s @ 100 MHz); >= 2
//  CNT_W         26          timer width; must hold max(HOLD_CYCLES, REPEAT_CYCLES)-1
// PORTS
//  clk            in   1     system clock
//  reset_n        in   1     synchronous reset, active-low
//  up_level       in   1     debounced UP button level (1 = pressed)
//  dn_level       in   1     debounced DOWN button level (1 = pressed)
//  ch_idx         out  CH_W  current channel index, registered
//  ch_tick        out  1     1-cycle pulse in the same cycle ch_idx shows a new value
//  repeat_active  out  1     1 while in REPEAT_UP or REPEAT_DN
// BEHAVIOUR
//  Reset (reset_n = 0 at posedge clk):
//   - state = IDLE, timer = 0, ch_idx = 0, ch_tick = 0, repeat_active = 0.
//   - Overrides every other event in that cycle.
//  States: IDLE, HOLD_UP, REPEAT_UP, HOLD_DN, REPEAT_DN, LOCK. All outputs are registered.
//  Steps:
//   - INC: ch_idx = (ch_idx == N_CH-1) ? 0 : ch_idx+1.
//   - DEC: ch_idx = (ch_idx == 0) ? N_CH-1 : ch_idx-1.
//   - Each step asserts ch_tick for exactly the one cycle in which the new ch_idx is visible.
//  IDLE:
//   - up & ~dn -> INC, timer = HOLD_CYCLES-1, go HOLD_UP.
//   - dn & ~up -> DEC, timer = HOLD_CYCLES-1, go HOLD_DN.
//   - up & dn -> no step, go LOCK.
//   - Latency: button sampled high at edge k -> ch_idx/ch_tick updated at edge k (visible cycle k+1).
//  HOLD_UP (HOLD_DN symmetric, with DEC):
//   - dn_level = 1 -> LOCK, no step.
//   - else up_level = 0 -> IDLE, no step.
//   - else timer == 0 -> INC, timer = REPEAT_CYCLES-1, go REPEAT_UP.
//   - else timer - 1.
//   - First repeat step is exactly HOLD_CYCLES cycles after the first step.
//  REPEAT_UP (REPEAT_DN symmetric):
//   - Same exit rules as HOLD_UP.
//   - On timer == 0: INC, timer = REPEAT_CYCLES-1.
//   - Steps exactly REPEAT_CYCLES apart.
//  LOCK: no steps; stays until up_level = 0 and dn_level = 0, then IDLE.
//   - Releasing only one button never produces a step.
//  Boundaries:
//   - Wrap-around is seamless in both directions, including during auto-repeat.
//   - A release in the same cycle the timer hits 0 -> no step (release wins).
//   - Reset mid-hold returns to IDLE. A button still held when reset_n rises counts as a new press (one step next cycle).
//  Timer is an unsigned down counter of CNT_W bits. It never underflows, because every state that uses it reloads at 0.
// TESTING (bench params: N_CH=13, HOLD_CYCLES=8, REPEAT_CYCLES=3)
//  1. Reset, then up_level high for 1 cycle -> ch_idx 0->1, one ch_tick, repeat_active stays 0.
//  2. dn_level pulse from ch_idx=0 -> ch_idx=12. Then up_level pulse -> ch_idx=0 (wrap both directions).
//  3. up_level held 20 cycles from 0 -> steps at t=0, 8, 11, 14, 17 -> ch_idx=5.
//     - repeat_active high from t=8 until the cycle after release.
//  4. up held, dn raised at t=5 -> LOCK, no further steps.
//     - Drop up, keep dn -> still no step.
//     - Drop dn -> IDLE; next up pulse steps +1.
//  5. up and dn rise in the same cycle from IDLE -> no step, LOCK until both low.
//  6. reset_n low at t=10 of an up hold with up still high -> ch_idx=0 during reset.
//     - ch_idx=1 one cycle after reset_n rises.
//     - Next step 8 cycles later.

Source files
------------

// File: rtl/channel_selector.sv
// channel_selector: turns debounced up/down button levels into a wrapping channel index with hold-to-repeat
module channel_selector #(
   parameter int N_CH          = 13,
   parameter int CH_W          = 4,
   parameter int HOLD_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            up_level,
   input  logic            dn_level,
   output logic [CH_W-1:0] ch_idx,
   output logic            ch_tick,
   output logic            repeat_active
);
   typedef enum logic [2:0] {IDLE, HOLD_UP, REPEAT_UP, HOLD_DN, REPEAT_DN, LOCK} state_t;
   localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYCLES - 1);
   localparam logic [CH_W-1:0]  LAST    = CH_W'(N_CH - 1);
   state_t           state;
   logic [CNT_W-1:0] timer;
   logic [CH_W-1:0]  nxt_up, nxt_dn;
   always_comb begin
      nxt_up = (ch_idx == LAST) ? '0 : ch_idx + 1'b1;
      nxt_dn = (ch_idx == '0) ? LAST : ch_idx - 1'b1;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         timer         <= '0;
         ch_idx        <= '0;
         ch_tick       <= 1'b0;
         repeat_active <= 1'b0;
      end else begin
         ch_tick       <= 1'b0;
         repeat_active <= 1'b0;
         case (state)
            IDLE: begin
               if (up_level && !dn_level) begin
                  ch_idx  <= nxt_up;
                  ch_tick <= 1'b1;
                  timer   <= HOLD_LD;
                  state   <= HOLD_UP;
               end else if (dn_level && !up_level) begin
                  ch_idx  <= nxt_dn;
                  ch_tick <= 1'b1;
                  timer   <= HOLD_LD;
                  state   <= HOLD_DN;
               end else if (up_level && dn_level) begin
                  state <= LOCK;
               end
            end
            HOLD_UP, REPEAT_UP: begin
               if (dn_level) begin
                  state <= LOCK;
               end else if (!up_level) begin
                  state <= IDLE;
               end else if (timer == '0) begin
                  ch_idx        <= nxt_up;
                  ch_tick       <= 1'b1;
                  timer         <= REP_LD;
                  state         <= REPEAT_UP;
                  repeat_active <= 1'b1;
               end else begin
                  timer         <= timer - 1'b1;
                  repeat_active <= (state == REPEAT_UP);
               end
            end
            HOLD_DN, REPEAT_DN: begin
               if (up_level) begin
                  state <= LOCK;
               end else if (!dn_level) begin
                  state <= IDLE;
               end else if (timer == '0) begin
                  ch_idx        <= nxt_dn;
                  ch_tick       <= 1'b1;
                  timer         <= REP_LD;
                  state         <= REPEAT_DN;
                  repeat_active <= 1'b1;
               end else begin
                  timer         <= timer - 1'b1;
                  repeat_active <= (state == REPEAT_DN);
               end
            end
            LOCK: if (!up_level && !dn_level) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_channel_selector.sv
// tb_channel_selector: directed and random stimulus checked against a press-age reference model
module tb_channel_selector;
   localparam int N = 13;
   localparam int H = 8;
   localparam int R = 3;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       up_level = 1'b0;
   logic       dn_level = 1'b0;
   logic [3:0] ch_idx;
   logic       ch_tick;
   logic       repeat_active;
   int checks = 0;
   int passed = 0;
   int m_idx = 0, m_dir = 0, m_age = 0;
   bit m_tick = 0, m_rep = 0, m_lock = 0;
   channel_selector #(.N_CH(N), .CH_W(4), .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .up_level(up_level), .dn_level(dn_level),
      .ch_idx(ch_idx), .ch_tick(ch_tick), .repeat_active(repeat_active)
   );
   always #5 clk = ~clk;
   // model: step on press, then at press ages H, H+R, H+2R ... while the same single button stays held
   task automatic model(input bit u, input bit d, input bit rn);
      bit stp = 0;
      m_tick = 0;
      if (!rn) begin
         m_idx = 0; m_dir = 0; m_age = 0; m_lock = 0;
      end else if (m_lock) begin
         if (!u && !d) m_lock = 0;
      end else if (m_dir == 0) begin
         if (u && d) m_lock = 1;
         else if (u || d) begin m_dir = u ? 1 : -1; m_age = 0; stp = 1; end
      end else if ((m_dir > 0) ? d : u) begin
         m_dir = 0; m_lock = 1;
      end else if (!((m_dir > 0) ? u : d)) begin
         m_dir = 0;
      end else begin
         m_age++;
         stp = (m_age == H) || (m_age > H && (m_age - H) % R == 0);
      end
      if (stp) begin m_idx = (m_idx + m_dir + N) % N; m_tick = 1; end
      m_rep = (m_dir != 0) && (m_age >= H);
   endtask
   task automatic chk(input string tag);
      checks++;
      assert (ch_idx === 4'(m_idx)) passed++;
      else $error("FAIL %s ch_idx: got %0d want %0d", tag, ch_idx, m_idx);
      checks++;
      assert (ch_tick === m_tick) passed++;
      else $error("FAIL %s ch_tick: got %b want %b", tag, ch_tick, m_tick);
      checks++;
      assert (repeat_active === m_rep) passed++;
      else $error("FAIL %s repeat_active: got %b want %b", tag, repeat_active, m_rep);
   endtask
   task automatic cyc(input bit u, input bit d, input bit rn, input string tag);
      @(negedge clk);
      up_level = u; dn_level = d; reset_n = rn;
      @(posedge clk);
      model(u, d, rn);
      #1 chk(tag);
   endtask
   task automatic fixed(input string tag, input int idx);
      checks++;
      assert (ch_idx === 4'(idx)) passed++;
      else $error("FAIL %s: ch_idx got %0d want %0d", tag, ch_idx, idx);
   endtask
   task automatic rst();
      cyc(0, 0, 0, "reset"); cyc(0, 0, 0, "reset");
      cyc(0, 0, 1, "idle");
   endtask
   initial begin
      rst();
      fixed("reset_idx", 0);
      cyc(1, 0, 1, "t1_press"); cyc(0, 0, 1, "t1_rel"); cyc(0, 0, 1, "t1_idle");
      fixed("t1_result", 1);
      rst();
      cyc(0, 1, 1, "t2_dn"); cyc(0, 0, 1, "t2_rel");
      fixed("t2_wrap_dn", 12);
      cyc(1, 0, 1, "t2_up"); cyc(0, 0, 1, "t2_rel2");
      fixed("t2_wrap_up", 0);
      rst();
      for (int i = 0; i < 20; i++) cyc(1, 0, 1, "t3_hold");
      cyc(0, 0, 1, "t3_rel"); cyc(0, 0, 1, "t3_idle");
      fixed("t3_result", 5);
      rst();
      for (int i = 0; i < 5; i++) cyc(1, 0, 1, "t4_up");
      for (int i = 0; i < 12; i++) cyc(1, 1, 1, "t4_lock");
      for (int i = 0; i < 4; i++) cyc(0, 1, 1, "t4_dn_only");
      cyc(0, 0, 1, "t4_release"); cyc(1, 0, 1, "t4_press"); cyc(0, 0, 1, "t4_rel");
      fixed("t4_result", 2);
      rst();
      for (int i = 0; i < 6; i++) cyc(1, 1, 1, "t5_both");
      cyc(1, 0, 1, "t5_up_only"); cyc(0, 0, 1, "t5_rel"); cyc(0, 0, 1, "t5_idle");
      fixed("t5_result", 0);
      rst();
      for (int i = 0; i < 10; i++) cyc(1, 0, 1, "t6_hold");
      cyc(1, 0, 0, "t6_reset"); cyc(1, 0, 0, "t6_reset");
      fixed("t6_in_reset", 0);
      cyc(1, 0, 1, "t6_repress");
      fixed("t6_after", 1);
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, "t6_hold2");
      fixed("t6_next", 2);
      cyc(0, 0, 1, "t6_rel");
      for (int s = 0; s < 150; s++) begin
         int len = $urandom_range(1, 25);
         int p = $urandom_range(0, 9);
         bit u = (p < 4) || (p == 8);
         bit d = (p >= 4 && p < 8) || (p == 8);
         bit rn = ($urandom_range(0, 29) != 0);
         for (int i = 0; i < len; i++) cyc(u, d, rn || i > 1, "random");
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
